mem_bus_arbiter: RTL

- Shares the single memory bus (32-bit data, 4-bit address, read/write strobes) between N_REQ masters.
- Typical masters: memory controller, DMA, debug port.
- Round-robin arbitration, one transaction in flight at a time.
- Drives the bus-side strobes toward the RAM/cache slave and returns read data and completion to the winning requester.
- Sits between the requesters and the bus interface instance in top.

---
 rtl/mem_bus_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one memory bus between N_REQ masters.
// One transaction is in flight at a time. Outputs are decoded from state
// and registers only, so there is no combinational path from req.
module mem_bus_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         bus_address,
  output logic [DATA_W-1:0]         bus_wdata,
  output logic                      bus_read,
  output logic                      bus_write,
  input  logic [DATA_W-1:0]         bus_rdata
);

  localparam int PW = $clog2(N_REQ);
  localparam int unsigned NU = N_REQ;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t              state, state_nx;
  logic [PW-1:0]       ptr, ptr_nx;      // last winner; also the current owner
  logic                we_r, we_nx;
  logic [ADDR_W-1:0]   addr_r, addr_nx;
  logic [DATA_W-1:0]   wdata_r, wdata_nx;
  logic [3:0]          cnt, cnt_nx;
  logic [DATA_W-1:0]   rdata_r, rdata_nx;

  logic                found;
  logic [PW-1:0]       win;

  // Round-robin search: first set req bit starting just after ptr, with wrap.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    win   = ptr;
    for (int unsigned i = 1; i <= NU; i++) begin
      idx = (32'(ptr) + i) % NU;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Next-state and datapath register update logic.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    we_nx    = we_r;
    addr_nx  = addr_r;
    wdata_nx = wdata_r;
    cnt_nx   = cnt;
    rdata_nx = rdata_r;
    unique case (state)
      IDLE: begin
        if (found) begin
          ptr_nx   = win;
          we_nx    = req_we[win];
          addr_nx  = req_addr[win*ADDR_W +: ADDR_W];
          wdata_nx = req_wdata[win*DATA_W +: DATA_W];
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (we_r) begin
          state_nx = IDLE;
        end else begin
          cnt_nx   = 4'(RD_LAT - 1);
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          rdata_nx = bus_rdata;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= PW'(N_REQ - 1);
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      cnt     <= '0;
      rdata_r <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      we_r    <= we_nx;
      addr_r  <= addr_nx;
      wdata_r <= wdata_nx;
      cnt     <= cnt_nx;
      rdata_r <= rdata_nx;
    end
  end

  // Output decode from state and registers; reset clears them immediately.
  always_comb begin
    gnt       = '0;
    done      = '0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    if (state != IDLE) gnt[ptr] = 1'b1;
    if ((state == ACCESS && we_r) || state == RESP) done[ptr] = 1'b1;
    if (state == ACCESS) begin
      bus_read  = ~we_r;
      bus_write = we_r;
    end
  end

  assign bus_address = addr_r;
  assign bus_wdata   = wdata_r;
  assign rdata       = rdata_r;

endmodule
